// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB first, valid/ready load, shift_en paced.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  // state  | meaning
  // IDLE   | no frame, ready for a word
  // SHIFT  | data bits on s_out, cnt = index of current bit
  // PARITY | parity trailer on s_out (parity build only)

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam state_t DATA_DONE = PARITY;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
  localparam state_t DATA_DONE = IDLE;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             par_bit;

`ifdef PISO_TX_PARITY_EN
  logic par_q, par_d;
  assign last_bit = (state_q == PARITY);
  assign par_bit  = (state_q == PARITY) && par_q;
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign par_bit  = 1'b0;
`endif

  // The final bit of a frame doubles as the load slot for back-to-back frames.
  assign p_ready = !reset && ((state_q == IDLE) || (last_bit && shift_en));
  assign accept  = p_valid && p_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shreg_d = p_in;
      cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
      par_d   = ^p_in;
`endif
    end else if (shift_en) begin
      case (state_q)
        SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = DATA_DONE;
        end
`ifdef PISO_TX_PARITY_EN
        PARITY:  state_d = IDLE;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign busy    = !reset && (state_q != IDLE);
  assign s_valid = busy;
  assign s_out   = !reset && (((state_q == SHIFT) && shreg_q[WIDTH-1]) || par_bit);
  assign s_first = !reset && (state_q == SHIFT) && (cnt_q == '0);
  assign s_last  = !reset && last_bit;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus random traffic
// against a frame-level reference model (bit list per accepted word).
module tb_piso_tx;
  localparam int W = 16;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] p_in;
  logic         p_valid;
  logic         p_ready;
  logic         shift_en;
  logic         s_out, s_valid, s_first, s_last, busy;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
    .shift_en(shift_en), .s_out(s_out), .s_valid(s_valid), .s_first(s_first),
    .s_last(s_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame is a plain list of bits, idx points at the bit on the line.
  logic m_bits[FL];
  logic m_active = 1'b0;
  int   m_idx = 0;
  logic m_acc = 1'b0;

  logic seen_sout, seen_svalid, seen_slast, seen_first, seen_prdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [5:0] exp;
    exp = 6'b0;
    if (!reset) begin
      if (!m_active) exp[5] = 1'b1;
      else begin
        exp[5] = (m_idx == FL - 1) && shift_en;
        exp[4] = 1'b1;
        exp[3] = 1'b1;
        exp[2] = m_bits[m_idx];
        exp[1] = (m_idx == 0);
        exp[0] = (m_idx == FL - 1);
      end
    end
    chk({tag, " rdy/busy/sv/so/sf/sl"}, {26'b0, p_ready, busy, s_valid, s_out, s_first, s_last},
        {26'b0, exp});
    seen_sout   = s_out;
    seen_svalid = s_valid;
    seen_slast  = s_last;
    seen_first  = s_first;
    seen_prdy   = p_ready;
  endtask

  task automatic model_step();
    m_acc = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_idx    = 0;
    end else begin
      m_acc = p_valid && (!m_active || (m_idx == FL - 1 && shift_en));
      if (m_active && shift_en) begin
        m_idx++;
        if (m_idx == FL) m_active = 1'b0;
      end
      if (m_acc) begin
        for (int i = 0; i < W; i++) m_bits[i] = p_in[W-1-i];
        if (FL > W) m_bits[FL-1] = ($countones(p_in) % 2) == 1;
        m_idx    = 0;
        m_active = 1'b1;
      end
    end
  endtask

  // Inputs are applied just after a rising edge, checked on the falling edge.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic se,
                      input string tag);
    reset = rst; p_valid = v; p_in = d; shift_en = se;
    @(negedge clk);
    check_cycle(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] word;
    logic [2:0]   hold3;
    int           cnt;
    logic         r, se, hold_v;
    logic [W-1:0] hold_d;

    reset = 1'b1; p_valid = 1'b0; p_in = '0; shift_en = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 16'hFFFF, 1, "reset");
    step(1, 0, '0, 0, "reset");
    step(0, 0, '0, 1, "idle");
    chk("rst_ready", {31'b0, seen_prdy}, 32'd1);

    // T1
    step(0, 1, 16'hA5C3, 1, "t1");
    word = '0;
    for (int k = 1; k <= FL; k++) begin
      step(0, 0, '0, 1, "t1");
      if (k <= W) word = {word[W-2:0], seen_sout};
      if (k == 1) chk("t1_first", {31'b0, seen_first}, 32'd1);
      if (k == FL) chk("t1_last", {31'b0, seen_slast}, 32'd1);
    end
    chk("t1_word", {16'b0, word}, 32'h0000A5C3);
    step(0, 0, '0, 1, "t1_end");
    chk("t1_idle", {31'b0, seen_svalid}, 32'd0);

    // T2
    step(0, 1, 16'hFFFF, 1, "t2");
    cnt = 0;
    for (int k = 1; k <= 2 * FL; k++) begin
      step(0, k <= FL, 16'h0001, 1, "t2");
      cnt += int'(seen_svalid);
      if (k == FL) chk("t2_ready", {31'b0, seen_prdy}, 32'd1);
    end
    chk("t2_valid_run", cnt, 2 * FL);
    step(0, 0, '0, 1, "t2_end");

    // T3
    step(0, 1, 16'h8000, 1, "t3");
    cnt = 0;
    hold3 = '0;
    for (int k = 1; k <= 2 * FL + 3; k++) begin
      step(0, 0, '0, (k % 2) == 0, "t3");
      cnt += int'(seen_svalid);
      if (k <= 3) hold3 = {hold3[1:0], seen_sout};
    end
    chk("t3_hold", {29'b0, hold3}, 32'd6);
    chk("t3_len", cnt, 2 * FL);

    // T4
    step(0, 1, 16'h1234, 1, "t4");
    for (int k = 1; k <= 7; k++) step(0, 0, '0, 1, "t4");
    step(1, 0, '0, 1, "t4_rst");
    step(0, 0, '0, 1, "t4_after");
    chk("t4_svalid", {31'b0, seen_svalid}, 32'd0);
    chk("t4_ready", {31'b0, seen_prdy}, 32'd1);
    step(0, 1, 16'h5555, 1, "t4_new");
    step(0, 0, '0, 1, "t4_new");
    chk("t4_first", {31'b0, seen_first}, 32'd1);
    for (int k = 2; k <= FL + 1; k++) step(0, 0, '0, 1, "t4_new");

    // T5
    step(0, 1, 16'h1357, 1, "t5");
    word = '0;
    for (int k = 1; k <= FL; k++) begin
      step(0, k == 4, (k == 4) ? 16'hDEAD : 16'h0000, 1, "t5");
      if (k <= W) word = {word[W-2:0], seen_sout};
    end
    chk("t5_word", {16'b0, word}, 32'h00001357);
    step(0, 0, '0, 1, "t5_end");
    chk("t5_idle", {31'b0, seen_svalid}, 32'd0);

`ifdef PISO_TX_PARITY_EN
    // T6
    step(0, 1, 16'h0001, 1, "t6");
    for (int k = 1; k <= FL; k++) begin
      step(0, 0, '0, 1, "t6");
      if (k == FL) begin
        chk("t6_par1", {30'b0, seen_sout, seen_slast}, 32'd3);
      end
    end
    step(0, 1, 16'h0003, 1, "t6b");
    for (int k = 1; k <= FL; k++) begin
      step(0, 0, '0, 1, "t6b");
      if (k == FL) begin
        chk("t6_par0", {30'b0, seen_sout, seen_slast}, 32'd1);
      end
    end
`endif

    // Random traffic; upstream holds a word until it is taken.
    hold_v = 1'b0;
    hold_d = '0;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      se = ($urandom_range(0, 3) != 0);
      if (!hold_v && $urandom_range(0, 2) == 0) begin
        hold_v = 1'b1;
        hold_d = W'($urandom);
      end
      step(r, hold_v, hold_d, se, "rand");
      if (m_acc || r) hold_v = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
